host_cmd_bridge: RTL

Byte-stream command bridge that sits directly upstream of the design top-level's host memory port. It assembles host command frames (opcode, 64-bit address, optional 64-bit data) from an 8-bit valid/ready receive stream and issues exactly one memory operation per frame. It waits out the top-level's read latency, then returns read data, a write acknowledgement, or an error byte on an 8-bit valid/ready transmit stream.

---
 rtl/host_cmd_bridge_pkg.sv | 34 +++
 rtl/host_cmd_bridge_if.sv | 32 +++
 rtl/host_tx_ser.sv | 53 +++++
 rtl/host_cmd_bridge.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/host_cmd_bridge_pkg.sv
// host_cmd_bridge_pkg: shared widths, memory-op and host-opcode encodings,
// FSM state type and a byte shift-in helper for the host command bridge.
package host_cmd_bridge_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 64;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned LEN_W  = 4;

   typedef logic [1:0] mem_op_t;

   localparam mem_op_t MEM_OP_NOP   = 2'd0;
   localparam mem_op_t MEM_OP_READ  = 2'd1;
   localparam mem_op_t MEM_OP_WRITE = 2'd2;

   localparam logic [BYTE_W-1:0] HOST_OPC_READ  = 8'h01;
   localparam logic [BYTE_W-1:0] HOST_OPC_WRITE = 8'h02;

   typedef enum logic [2:0] {
      S_OP    = 3'd0,
      S_ADDR  = 3'd1,
      S_DATA  = 3'd2,
      S_ISSUE = 3'd3,
      S_WAIT  = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   // New byte enters at the top, so the first byte ends up in bits [7:0].
   function automatic logic [WORD_W-1:0] shift_in_byte(input logic [WORD_W-1:0] cur,
                                                       input logic [BYTE_W-1:0] b);
      return {b, cur[WORD_W-1:BYTE_W]};
   endfunction

endpackage

// File: rtl/host_cmd_bridge_if.sv
// host_cmd_bridge_if: byte receive/transmit streams plus the memory-port
// signals between the bridge and the design top-level.
//   rx_valid/rx_data/rx_ready : host -> bridge byte stream
//   tx_valid/tx_data/tx_ready : bridge -> host byte stream
//   mem_op/mem_addr/mem_wdata : bridge -> top-level request
//   mem_rdata/mem_op_pending  : top-level -> bridge read return
// Modport slave is the bridge side, master is the environment side.
interface host_cmd_bridge_if;

   logic                               rx_valid;
   logic [7:0]                         rx_data;
   logic                               rx_ready;
   logic                               tx_valid;
   logic [7:0]                         tx_data;
   logic                               tx_ready;
   host_cmd_bridge_pkg::mem_op_t       mem_op;
   logic [63:0]                        mem_addr;
   logic [63:0]                        mem_wdata;
   logic [63:0]                        mem_rdata;
   logic                               mem_op_pending;

   modport slave (
      input  rx_valid, rx_data, tx_ready, mem_rdata, mem_op_pending,
      output rx_ready, tx_valid, tx_data, mem_op, mem_addr, mem_wdata
   );

   modport master (
      output rx_valid, rx_data, tx_ready, mem_rdata, mem_op_pending,
      input  rx_ready, tx_valid, tx_data, mem_op, mem_addr, mem_wdata
   );

endinterface

// File: rtl/host_tx_ser.sv
// host_tx_ser: LSB-first valid/ready byte serializer for a 64-bit word,
// sending either 1 or 8 bytes per load.
//   clk, rst            : clock, synchronous active-high reset
//   load/load_data/len  : start a response (only while idle)
//   tx_valid/tx_data    : registered byte stream, held until tx_ready
//   tx_ready            : sink accepts current byte
//   done_c              : last byte accepted this cycle
module host_tx_ser
   import host_cmd_bridge_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WORD_W-1:0] load_data,
   input  logic [LEN_W-1:0]  load_len,
   input  logic              tx_ready,
   output logic              tx_valid,
   output logic [BYTE_W-1:0] tx_data,
   output logic              done_c
);

   logic [WORD_W-1:0] shreg;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  last;

   // shreg keeps the current byte in [7:0]; the next byte is pre-read from [15:8].
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg    <= '0;
         cnt      <= '0;
         last     <= '0;
         tx_valid <= 1'b0;
         tx_data  <= '0;
      end else if (load) begin
         shreg    <= load_data;
         cnt      <= '0;
         last     <= CNT_W'(load_len - LEN_W'(1));
         tx_valid <= 1'b1;
         tx_data  <= load_data[BYTE_W-1:0];
      end else if (tx_valid && tx_ready) begin
         if (cnt == last) begin
            tx_valid <= 1'b0;
         end else begin
            cnt     <= cnt + CNT_W'(1);
            shreg   <= shreg >> BYTE_W;
            tx_data <= shreg[2*BYTE_W-1:BYTE_W];
         end
      end
   end

   assign done_c = tx_valid && tx_ready && (cnt == last);

endmodule

// File: rtl/host_cmd_bridge.sv
// host_cmd_bridge: assembles host command frames (opcode, 64-bit address,
// optional 64-bit data) from a byte stream, issues one memory op per frame,
// waits out read latency and returns read data, ACK_BYTE or ERR_BYTE.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : byte streams and top-level memory port (slave side)
module host_cmd_bridge
   import host_cmd_bridge_pkg::*;
#(
   parameter logic [7:0] ACK_BYTE = 8'hA5,
   parameter logic [7:0] ERR_BYTE = 8'hEE
)
(
   input logic              i_clk,
   input logic              i_rst,
   host_cmd_bridge_if.slave bus
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   mem_op_t            op_q, op_d;
   logic [WORD_W-1:0]  addr_q, wdata_q;
   logic               rx_ready_q;
   mem_op_t            mem_op_q;

   logic               rx_fire_c;
   logic               addr_shift_c;
   logic               data_shift_c;
   logic               ser_load_c;
   logic [WORD_W-1:0]  ser_data_c;
   logic [LEN_W-1:0]   ser_len_c;
   logic               ser_done_c;
   logic               tx_valid;
   logic [BYTE_W-1:0]  tx_data;

   assign rx_fire_c = bus.rx_valid && rx_ready_q;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_OP;
         cnt_q   <= '0;
         op_q    <= MEM_OP_NOP;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   // Next-state and control decode
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op_d         = op_q;
      addr_shift_c = 1'b0;
      data_shift_c = 1'b0;
      ser_load_c   = 1'b0;
      ser_data_c   = '0;
      ser_len_c    = LEN_W'(1);
      case (state_q)
         S_OP: begin
            if (rx_fire_c) begin
               cnt_d = '0;
               if (bus.rx_data == HOST_OPC_READ) begin
                  op_d    = MEM_OP_READ;
                  state_d = S_ADDR;
               end else if (bus.rx_data == HOST_OPC_WRITE) begin
                  op_d    = MEM_OP_WRITE;
                  state_d = S_ADDR;
               end else begin
                  // Unknown opcode: answer at once, nothing else of the frame is consumed.
                  state_d    = S_RESP;
                  ser_load_c = 1'b1;
                  ser_data_c = {{(WORD_W-BYTE_W){1'b0}}, ERR_BYTE};
               end
            end
         end
         S_ADDR: begin
            if (rx_fire_c) begin
               addr_shift_c = 1'b1;
               cnt_d        = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(7)) begin
                  state_d = (op_q == MEM_OP_WRITE) ? S_DATA : S_ISSUE;
               end
            end
         end
         S_DATA: begin
            if (rx_fire_c) begin
               data_shift_c = 1'b1;
               cnt_d        = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(7)) begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            cnt_d = '0;
            if (op_q == MEM_OP_READ) begin
               state_d = S_WAIT;
            end else begin
               state_d    = S_RESP;
               ser_load_c = 1'b1;
               ser_data_c = {{(WORD_W-BYTE_W){1'b0}}, ACK_BYTE};
            end
         end
         S_WAIT: begin
            if (!bus.mem_op_pending) begin
               state_d    = S_RESP;
               ser_load_c = 1'b1;
               ser_data_c = bus.mem_rdata;
               ser_len_c  = LEN_W'(8);
            end
         end
         S_RESP: begin
            if (ser_done_c) begin
               state_d = S_OP;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_OP;
            cnt_d   = '0;
         end
      endcase
   end

   // Registered outputs derived from the upcoming state; reset forces NOP.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_ready_q <= 1'b1;
         mem_op_q   <= MEM_OP_NOP;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         rx_ready_q <= (state_d == S_OP) || (state_d == S_ADDR) || (state_d == S_DATA);
         mem_op_q   <= (state_d == S_ISSUE) ? op_d : MEM_OP_NOP;
         if (addr_shift_c) begin
            addr_q <= shift_in_byte(addr_q, bus.rx_data);
         end
         if (data_shift_c) begin
            wdata_q <= shift_in_byte(wdata_q, bus.rx_data);
         end
      end
   end

   host_tx_ser u_tx_ser (
      .clk       (i_clk),
      .rst       (i_rst),
      .load      (ser_load_c),
      .load_data (ser_data_c),
      .load_len  (ser_len_c),
      .tx_ready  (bus.tx_ready),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .done_c    (ser_done_c)
   );

   assign bus.rx_ready  = rx_ready_q;
   assign bus.tx_valid  = tx_valid;
   assign bus.tx_data   = tx_data;
   assign bus.mem_op    = mem_op_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

endmodule
